// File: rtl/mmio_bridge_pkg.sv
// Types and constants shared by the Rx and Tx MMIO bridges: completion-tracking
// sideband, supported request encodings and the power-user request header layout.
package mmio_bridge_pkg;

  localparam int MAX_LEN_DW = 2;

  localparam logic [7:0] FMT_MRD32 = 8'h00;
  localparam logic [7:0] FMT_MRD64 = 8'h20;
  localparam logic [7:0] FMT_MWR32 = 8'h40;
  localparam logic [7:0] FMT_MWR64 = 8'h60;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } rx_state_e;

  // Completion-tracking entry queued by the Tx bridge for every accepted read.
  typedef struct packed {
    logic [9:0]  tag;
    logic [13:0] length;
    logic [15:0] req_id;
    logic [23:0] low_addr;
  } ctt_t;

  // Header occupies tdata[255:0]; DW0 sits in the least significant 32 bits.
  typedef struct packed {
    logic [127:0] rsvd;
    logic [29:0]  host_addr_l;
    logic [1:0]   ph;
    logic [31:0]  host_addr_h;
    logic [15:0]  req_id;
    logic [7:0]   tag_l;
    logic [3:0]   last_dw_be;
    logic [3:0]   first_dw_be;
    logic [7:0]   fmt_type;
    logic         tag_h;
    logic [2:0]   tc;
    logic         tag_m;
    logic         attr_h;
    logic         ln;
    logic         th;
    logic         td;
    logic         ep;
    logic [1:0]   attr_l;
    logic [1:0]   at;
    logic [9:0]   length;
  } pu_req_hdr_t;

  function automatic logic is_4dw(input logic [7:0] fmt_type);
    return fmt_type[5];
  endfunction

  function automatic logic [13:0] dw_to_bytes(input logic [9:0] length_dw);
    return {2'b00, length_dw, 2'b00};
  endfunction

endpackage

// File: rtl/axis_rx_mmio_decode.sv
// Combinational decode of one power-user MMIO request header plus its first
// 64 payload bits into an AVMM command and the read completion-tracking entry.
module axis_rx_mmio_decode
  import mmio_bridge_pkg::*;
#(
  parameter int AVMM_ADDR_WIDTH = 20
) (
  input  logic [255:0]                hdr,
  input  logic [63:0]                 payload,
  output logic                        is_rd,
  output logic                        is_wr,
  output logic                        supported,
  output logic [AVMM_ADDR_WIDTH-1:0]  addr,
  output logic [7:0]                  byteenable,
  output logic [63:0]                 wdata,
  output ctt_t                        ctt
);

  pu_req_hdr_t h;
  logic [63:0] full_addr;
  logic        len_ok;
  logic        unused_hdr;

  assign h = pu_req_hdr_t'(hdr);

  always_comb begin
    full_addr = '0;
    if (is_4dw(h.fmt_type)) begin
      full_addr = {h.host_addr_h, h.host_addr_l, 2'b00};
    end else begin
      full_addr = {32'h0, h.host_addr_l, 2'b00};
    end

    is_rd = (h.fmt_type == FMT_MRD32) || (h.fmt_type == FMT_MRD64);
    is_wr = (h.fmt_type == FMT_MWR32) || (h.fmt_type == FMT_MWR64);

    // A 2DW access must fill one aligned 64-bit word; straddling two is dropped.
    len_ok = (h.length == 10'd1) ||
             ((h.length == 10'(MAX_LEN_DW)) && !full_addr[2]);
    supported = (is_rd || is_wr) && len_ok;

    addr = {full_addr[AVMM_ADDR_WIDTH-1:3], 3'b000};

    if (h.length == 10'd1) begin
      byteenable = full_addr[2] ? {h.first_dw_be, 4'h0} : {4'h0, h.first_dw_be};
    end else begin
      byteenable = {h.last_dw_be, h.first_dw_be};
    end

    wdata = full_addr[2] ? {payload[31:0], 32'h0} : payload;

    ctt.tag      = {h.tag_h, h.tag_m, h.tag_l};
    ctt.length   = dw_to_bytes(h.length);
    ctt.req_id   = h.req_id;
    ctt.low_addr = {17'b0, full_addr[6:0]};
  end

  assign unused_hdr = ^{h.rsvd, h.ph, h.tc, h.attr_h, h.ln, h.th, h.td, h.ep,
                        h.attr_l, h.at, full_addr[63:AVMM_ADDR_WIDTH],
                        full_addr[1:0]};

endmodule

// File: rtl/axis_rx_mmio_bridge.sv
// Rx MMIO bridge: single-beat request TLPs in, AVMM read/write commands out.
// Optional saturating drop counter enabled by defining AXIS_RX_MMIO_ERR_CNT_EN.
module axis_rx_mmio_bridge
  import mmio_bridge_pkg::*;
#(
  parameter int AVMM_ADDR_WIDTH    = 20,
  parameter int AVMM_DATA_WIDTH    = 64,
  parameter int MAX_OUTSTANDING_RD = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,

  input  logic                        axis_rx_tvalid,
  output logic                        axis_rx_tready,
  input  logic [511:0]                axis_rx_tdata,
  input  logic                        axis_rx_tlast,

  output logic [AVMM_ADDR_WIDTH-1:0]  avmm_m2s_address,
  output logic                        avmm_m2s_read,
  output logic                        avmm_m2s_write,
  output logic [AVMM_DATA_WIDTH-1:0]  avmm_m2s_writedata,
  output logic [7:0]                  avmm_m2s_byteenable,
  input  logic                        avmm_s2m_waitrequest,
  input  logic                        avmm_s2m_readdatavalid,

  output logic                        tlp_rd_strb,
  output logic [9:0]                  tlp_rd_tag,
  output logic [13:0]                 tlp_rd_length,
  output logic [15:0]                 tlp_rd_req_id,
  output logic [23:0]                 tlp_rd_low_addr,

  output logic                        rx_error,
  output logic [15:0]                 rx_error_cnt,
  output logic [1:0]                  state_dbg
);

  // Handshakes: an AXI-S beat transfers on a rising edge where tvalid && tready;
  // tready is registered and never depends on tvalid. An AVMM command stays
  // stable until the rising edge on which waitrequest is low, where it completes.

  localparam int CNT_W = $clog2(MAX_OUTSTANDING_RD + 1);

  rx_state_e                   state;
  logic [CNT_W-1:0]            rd_cnt;
  logic [CNT_W-1:0]            rd_cnt_nxt;
  logic                        rd_accept;
  logic                        rdv_take;
  logic                        cnt_open;
  logic                        beat;

  logic                        dec_is_rd;
  logic                        dec_is_wr;
  logic                        dec_supported;
  logic [AVMM_ADDR_WIDTH-1:0]  dec_addr;
  logic [7:0]                  dec_be;
  logic [63:0]                 dec_wdata;
  ctt_t                        dec_ctt;
  ctt_t                        ctt_q;
  logic                        unused_tdata;

  axis_rx_mmio_decode #(
    .AVMM_ADDR_WIDTH (AVMM_ADDR_WIDTH)
  ) u_decode (
    .hdr        (axis_rx_tdata[255:0]),
    .payload    (axis_rx_tdata[319:256]),
    .is_rd      (dec_is_rd),
    .is_wr      (dec_is_wr),
    .supported  (dec_supported),
    .addr       (dec_addr),
    .byteenable (dec_be),
    .wdata      (dec_wdata),
    .ctt        (dec_ctt)
  );

  always_comb begin
    rd_accept  = avmm_m2s_read & ~avmm_s2m_waitrequest;
    rdv_take   = avmm_s2m_readdatavalid & (rd_cnt != '0);
    rd_cnt_nxt = rd_cnt + CNT_W'(rd_accept) - CNT_W'(rdv_take);
    // tready is registered, so the credit check looks at next cycle's count.
    cnt_open   = rd_cnt_nxt < CNT_W'(MAX_OUTSTANDING_RD);
    beat       = axis_rx_tvalid & axis_rx_tready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt <= '0;
    end else begin
      rd_cnt <= rd_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= IDLE;
      axis_rx_tready      <= 1'b0;
      avmm_m2s_read       <= 1'b0;
      avmm_m2s_write      <= 1'b0;
      avmm_m2s_address    <= '0;
      avmm_m2s_writedata  <= '0;
      avmm_m2s_byteenable <= '0;
      ctt_q               <= '0;
      rx_error            <= 1'b0;
    end else begin
      rx_error <= 1'b0;
      case (state)
        IDLE: begin
          axis_rx_tready <= cnt_open;
          if (beat) begin
            if (!axis_rx_tlast) begin
              state          <= DRAIN;
              axis_rx_tready <= 1'b1;
              rx_error       <= 1'b1;
            end else if (!dec_supported) begin
              rx_error <= 1'b1;
            end else begin
              state               <= ISSUE;
              axis_rx_tready      <= 1'b0;
              avmm_m2s_read       <= dec_is_rd;
              avmm_m2s_write      <= dec_is_wr;
              avmm_m2s_address    <= dec_addr;
              avmm_m2s_writedata  <= dec_wdata;
              avmm_m2s_byteenable <= dec_be;
              if (dec_is_rd) begin
                ctt_q <= dec_ctt;
              end
            end
          end
        end
        ISSUE: begin
          if (!avmm_s2m_waitrequest) begin
            state          <= IDLE;
            avmm_m2s_read  <= 1'b0;
            avmm_m2s_write <= 1'b0;
            axis_rx_tready <= cnt_open;
          end
        end
        DRAIN: begin
          if (beat && axis_rx_tlast) begin
            state          <= IDLE;
            axis_rx_tready <= cnt_open;
          end
        end
        default: begin
          state          <= IDLE;
          axis_rx_tready <= 1'b0;
        end
      endcase
    end
  end

  // The sideband must line up with the accepting cycle, so the strobe is not registered.
  assign tlp_rd_strb     = rd_accept;
  assign tlp_rd_tag      = ctt_q.tag;
  assign tlp_rd_length   = ctt_q.length;
  assign tlp_rd_req_id   = ctt_q.req_id;
  assign tlp_rd_low_addr = ctt_q.low_addr;
  assign state_dbg       = state;

`ifdef AXIS_RX_MMIO_ERR_CNT_EN
  logic [15:0] err_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if (rx_error && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign rx_error_cnt = err_cnt_q;
`else
  assign rx_error_cnt = 16'h0000;
`endif

  assign unused_tdata = ^axis_rx_tdata[511:320];

endmodule
